// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks: default geometry,
// pointer-width derivation and binary/Gray conversion helpers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 4;
  localparam int unsigned FIFO_AF_MARGIN  = 2;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned fifo_pw(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // Operates on a zero-extended 32-bit value, so any pointer width up to 32 works.
  function automatic logic [31:0] fifo_bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result exact.
  function automatic logic [31:0] fifo_gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int unsigned i = 31; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing clock domains.
module fifo_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Capture the foreign-domain value, then give it a full cycle to settle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and status logic of an asynchronous FIFO: binary/Gray
// write pointer, synchronized read pointer, registered full/level/almost-full
// and a sticky overflow flag.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned AF_MARGIN  = FIFO_AF_MARGIN
) (
  input  logic                  g_clk,
  input  logic                  w_rst,
  input  logic                  winc,
  input  logic                  wovf_clr,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  wovf
);

  localparam int unsigned   PW       = fifo_pw(ADDR_WIDTH);
  localparam int unsigned   DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;

  logic [PW-1:0] wbin_q,         wbin_d;
  logic [PW-1:0] wgray_q,        wgray_d;
  logic [PW-1:0] wlevel_q,       wlevel_d;
  logic          wfull_q,        wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          wovf_q,         wovf_d;

  // Raw rptr_gray is touched only by the synchronizer.
  fifo_sync_2ff #(
    .WIDTH (PW)
  ) u_rsync (
    .clk_i  (g_clk),
    .rst_ni (w_rst),
    .d_i    (rptr_gray),
    .q_o    (rq2)
  );

  assign wclken = winc & ~wfull_q;

  // Next-state pointer and status computation from the write pointer and the synchronized read pointer.
  always_comb begin
    rbin           = PW'(fifo_gray2bin(32'(rq2)));
    wbin_d         = wbin_q + PW'(wclken);
    wgray_d        = PW'(fifo_bin2gray(32'(wbin_d)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    wfull_d        = (wgray_d == {~rq2[PW-1:PW-2], rq2[PW-3:0]});
    wlevel_d       = wbin_d - rbin;
    walmost_full_d = (wlevel_d >= AF_LEVEL);
    wovf_d         = wovf_q;
    if (winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (wovf_clr) begin
      wovf_d = 1'b0;
    end
  end

  // State registers for the pointers and status flags.
  always_ff @(posedge g_clk or negedge w_rst) begin
    if (!w_rst) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_WIDTH=4, AF_MARGIN=2).
module tb_fifo_wptr_full;

  localparam int AW    = 4;
  localparam int PW    = 5;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;

  logic          g_clk     = 1'b0;
  logic          w_rst     = 1'b0;
  logic          winc      = 1'b0;
  logic          wovf_clr  = 1'b0;
  logic [PW-1:0] rptr_gray = '0;
  logic          wclken;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [PW-1:0] wlevel;
  logic          wovf;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wptr_full #(
    .ADDR_WIDTH (AW),
    .AF_MARGIN  (AFM)
  ) dut (
    .g_clk        (g_clk),
    .w_rst        (w_rst),
    .winc         (winc),
    .wovf_clr     (wovf_clr),
    .rptr_gray    (rptr_gray),
    .wclken       (wclken),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int v);
    return (v ^ (v >> 1)) & 31;
  endfunction

  // Search-based decode: which count in 0..31 has this Gray code.
  function automatic int count_of(input int g);
    for (int k = 0; k < 32; k++) begin
      if (gray_of(k) == g) return k;
    end
    return 0;
  endfunction

  // Model: count of accepted writes, occupancy against the read pointer
  // observed two edges earlier, flags derived from occupancy.
  int m_wcnt  = 0;
  int m_level = 0;
  bit m_full  = 1'b0;
  bit m_af    = 1'b0;
  bit m_ovf   = 1'b0;
  int m_rsamp[$] = '{0, 0};

  always @(posedge g_clk or negedge w_rst) begin
    if (!w_rst) begin
      m_wcnt  = 0;
      m_level = 0;
      m_full  = 1'b0;
      m_af    = 1'b0;
      m_ovf   = 1'b0;
      m_rsamp = '{0, 0};
    end else begin
      if (winc && m_full) m_ovf = 1'b1;
      else if (wovf_clr)  m_ovf = 1'b0;
      if (winc && !m_full) m_wcnt = (m_wcnt + 1) % 32;
      m_rsamp.push_front(int'(rptr_gray));
      m_level = (m_wcnt - count_of(m_rsamp[2]) + 32) % 32;
      void'(m_rsamp.pop_back());
      m_full = (m_level == DEPTH);
      m_af   = (m_level >= DEPTH - AFM);
    end
  end

  always @(negedge g_clk) begin
    if (w_rst) begin
      chk("model_wclken", wclken, (winc && !m_full));
      chk("model_waddr", waddr, m_wcnt % DEPTH);
      chk("model_wptr_gray", wptr_gray, gray_of(m_wcnt));
      chk("model_wfull", wfull, m_full);
      chk("model_walmost_full", walmost_full, m_af);
      chk("model_wlevel", wlevel, m_level);
      chk("model_wovf", wovf, m_ovf);
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wlevel"}, wlevel, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wptr_gray"}, wptr_gray, 0);
    chk({tag, "_wfull"}, wfull, 0);
    chk({tag, "_walmost_full"}, walmost_full, 0);
    chk({tag, "_wovf"}, wovf, 0);
    chk({tag, "_wclken"}, wclken, 0);
  endtask

  task automatic fill_16(input string tag);
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1;
      tick();
      if (i == 13) chk({tag, "_af_after13"}, walmost_full, 0);
      if (i == 14) chk({tag, "_af_after14"}, walmost_full, 1);
      if (i == 15) chk({tag, "_full_after15"}, wfull, 0);
    end
    winc = 1'b0;
    chk({tag, "_full_after16"}, wfull, 1);
    chk({tag, "_level_after16"}, wlevel, 16);
    chk({tag, "_waddr_after16"}, waddr, 0);
    chk({tag, "_wptr_gray_after16"}, wptr_gray, 5'b11000);
  endtask

  task automatic reset_cycle();
    w_rst = 1'b0;
    tick();
    tick();
    w_rst = 1'b1;
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    w_rst = 1'b1;

    fill_16("fill");

    // Overflow attempt while full.
    winc = 1'b1;
    #1;
    chk("ovf_wclken_blocked", wclken, 0);
    tick();
    winc = 1'b0;
    chk("ovf_set", wovf, 1);
    chk("ovf_wptr_gray_held", wptr_gray, 5'b11000);
    chk("ovf_waddr_held", waddr, 0);
    chk("ovf_wlevel_held", wlevel, 16);
    repeat (3) tick();
    chk("ovf_sticky", wovf, 1);
    wovf_clr = 1'b1;
    tick();
    wovf_clr = 1'b0;
    chk("ovf_cleared", wovf, 0);
    winc     = 1'b1;
    wovf_clr = 1'b1;
    tick();
    winc     = 1'b0;
    wovf_clr = 1'b0;
    chk("ovf_set_wins", wovf, 1);
    wovf_clr = 1'b1;
    tick();
    wovf_clr = 1'b0;
    chk("ovf_cleared2", wovf, 0);

    // Read release seen on the third edge only.
    rptr_gray = 5'b00001;
    tick();
    chk("rel_e1_full", wfull, 1);
    chk("rel_e1_level", wlevel, 16);
    tick();
    chk("rel_e2_full", wfull, 1);
    chk("rel_e2_level", wlevel, 16);
    tick();
    chk("rel_e3_full", wfull, 0);
    chk("rel_e3_level", wlevel, 15);
    chk("rel_e3_af", walmost_full, 1);

    // Wrap: read pointer trails by 8 across the pointer MSB wrap.
    rptr_gray = '0;
    reset_cycle();
    for (int i = 1; i <= 8; i++) begin
      winc = 1'b1;
      tick();
    end
    winc = 1'b0;
    chk("wrap_level_start", wlevel, 8);
    for (int i = 9; i <= 32; i++) begin
      winc = 1'b1;
      tick();
      winc = 1'b0;
      rptr_gray = 5'(gray_of(i - 8));
      repeat (3) tick();
      chk("wrap_level", wlevel, 8);
    end
    chk("wrap_wptr_gray", wptr_gray, 0);
    chk("wrap_waddr", waddr, 0);

    // Reset in the middle of a fill.
    rptr_gray = '0;
    reset_cycle();
    for (int i = 1; i <= 10; i++) begin
      winc = 1'b1;
      tick();
    end
    winc = 1'b0;
    chk("mid_level10", wlevel, 10);
    #2;
    w_rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    w_rst = 1'b1;
    fill_16("refill");

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set RAM address width; DEPTH = 2**ADDR_WIDTH; pointer width PW = ADDR_WIDTH+1.
REQ-002 Parameter AF_MARGIN, default 2, SHALL set almost-full threshold (DEPTH-AF_MARGIN entries).
REQ-003 g_clk  input  1  write-domain clock; all state SHALL update on its rising edge.
REQ-004 w_rst  input  1  asynchronous, active-low reset.
REQ-005 winc  input  1  write request from producer.
REQ-006 wovf_clr  input  1  clears sticky overflow flag.
REQ-007 rptr_gray  input  PW  read pointer, Gray code, from read clock domain.
REQ-008 wclken  output  1  write enable to dual-port RAM.
REQ-009 waddr  output  ADDR_WIDTH  write address to RAM.
REQ-010 wptr_gray  output  PW  registered Gray write pointer, to read-domain synchronizer.
REQ-011 wfull  output  1  FIFO full.
REQ-012 walmost_full  output  1  level >= DEPTH-AF_MARGIN.
REQ-013 wlevel  output  PW  occupancy as seen from write domain, 0..DEPTH.
REQ-014 wovf  output  1  sticky: write attempted while full.

Function
REQ-015 wclken SHALL equal winc & ~wfull, combinationally.
REQ-016 Binary pointer wbin (PW bits) SHALL increment by 1 on each edge with wclken=1, wrapping modulo 2**PW.
REQ-017 waddr SHALL equal wbin[ADDR_WIDTH-1:0]; wraps DEPTH-1 -> 0.
REQ-018 wptr_gray SHALL be registered bin2gray(wbin_next), so it never glitches and changes at most one bit per edge.
REQ-019 rptr_gray SHALL pass through a two-flop synchronizer (rq2) before any use; no other logic SHALL touch raw rptr_gray.
REQ-020 wfull SHALL be registered: next value = (bin2gray(wbin_next) == {~rq2[PW-1:PW-2], rq2[PW-3:0]}).
REQ-021 wlevel SHALL be registered: wbin_next - gray2bin(rq2), modulo 2**PW.
REQ-022 walmost_full SHALL be registered: next value = (wlevel_next >= DEPTH-AF_MARGIN).
REQ-023 wfull SHALL assert on the same edge that accepts the DEPTH-th outstanding write (zero-cycle lag on the write side).
REQ-024 After rptr_gray changes, wfull/wlevel/walmost_full SHALL reflect it on the 3rd g_clk rising edge.
REQ-025 Simultaneous write and read release: both pointers SHALL be used in the same next-state computation; the write is accepted only if wfull=1 was not set at that edge.
REQ-026 wovf SHALL set on an edge with winc=1 and wfull=1; clear on wovf_clr=1; set wins when both occur together.
REQ-027 A write attempt while full SHALL not change wbin, waddr, wptr_gray or wlevel.

Reset
REQ-028 w_rst=0 SHALL immediately force wbin=0, waddr=0, wptr_gray=0, rq2 and first synchronizer stage=0, wfull=0, walmost_full=0, wlevel=0, wovf=0.
REQ-029 Reset mid-operation SHALL discard all state; no write SHALL be issued (wclken=0 since wfull=0 only when winc=0 is driven by producer during reset; RAM reset handles contents).
REQ-030 Reset release SHALL be synchronous to g_clk, provided upstream; block adds no deassertion synchronizer.

Structure
REQ-031 Package fifo_pkg SHALL hold default ADDR_WIDTH, PW derivation and bin2gray/gray2bin functions, shared with the read-side block.
REQ-032 Synchronizer SHALL be a separate sub-module fifo_sync_2ff (parameter WIDTH, async active-low reset), reused by the read side.

Verification (ADDR_WIDTH=4, AF_MARGIN=2)
REQ-033 Reset: w_rst=0 at any time -> all outputs 0 within the same cycle, wovf=0.
REQ-034 Fill: rptr_gray=0, 16 consecutive winc -> walmost_full=1 after 14th write, wfull=1 after 16th, wlevel=16, waddr=0, wptr_gray=5'b11000.
REQ-035 Overflow: full, winc=1 one cycle -> wclken=0, pointers unchanged, wovf=1 next edge, held until wovf_clr=1.
REQ-036 Release: full, rptr_gray 5'b00000->5'b00001 -> wfull=0, wlevel=15 on 3rd edge, not earlier.
REQ-037 Wrap: 32 writes with rptr_gray tracking at 8 behind -> wptr_gray returns to 5'b00000, wlevel stays 8 across MSB wrap.
REQ-038 Reset mid-fill: w_rst=0 at wlevel=10 -> wlevel=0, waddr=0 immediately; resume fill after release behaves as REQ-034.
